popcount_engine: RTL and testbench
==================================

Name: popcount_engine

Overview:
- Sequential producer of the ones-count of a data word; the generating end of the `$countones` check our assertion benches apply to a sampled signal.
- Accepts a WIDTH-bit word over a valid/ready handshake and counts CHUNK bits per clock.
- Returns the count and a nonzero flag over a second valid/ready handshake.
- Sits between a word source and any consumer, or an SVA checker, that needs bit-population results.

Parameters:
- WIDTH, 32: input word width; must be a multiple of CHUNK.
- CHUNK, 4: bits examined per COUNT cycle.
- CW, $clog2(WIDTH+1): derived, not user-set; count output width (6 for defaults).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  source presents in_data.
- in_ready  output  1  engine can accept a word.
- in_data  input  WIDTH  word to count.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- out_count  output  CW  number of 1 bits in the accepted word.
- out_nonzero  output  1  out_count != 0.
- busy  output  1  state != IDLE.

Behaviour:
- rst low, at any time including mid-operation: state goes to IDLE at once (asynchronous).
  - in_ready=0, out_valid=0, out_count=0, out_nonzero=0, busy=0; shift register and accumulator cleared.
  - in_ready rises to 1 one cycle after rst is released.
- FSM states: IDLE, COUNT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge T: capture in_data into the shift register, clear acc, clear chunk_idx, go to COUNT.
- COUNT (in_ready=0):
  - Each edge: acc += popcount(shreg[CHUNK-1:0]); shreg >>= CHUNK; chunk_idx++.
  - Go to DONE on the same edge if either:
    - (shreg >> CHUNK) == 0 (early exit), or
    - chunk_idx == WIDTH/CHUNK-1.
  - Cycle count k runs from 1 (word 0, or only low chunk set) to WIDTH/CHUNK (MSB chunk nonzero).
  - out_valid rises after edge T+k.
- DONE:
  - out_valid=1.
  - out_count and out_nonzero are registered and held stable while out_ready=0. No change of any kind while stalled.
  - On out_valid&&out_ready, go to IDLE. out_valid drops and in_ready rises on the next cycle; there is no same-cycle accept/complete bypass.
- Arithmetic:
  - acc is CW bits and cannot overflow (max WIDTH).
  - The per-chunk popcount is combinational over CHUNK bits.
- in_data is sampled only at the accept edge. Changes to it afterwards have no effect.
- in_valid while busy is ignored, not queued. The source must hold it until in_ready.
- Elaboration: WIDTH % CHUNK != 0, or CHUNK > WIDTH, triggers `$fatal`.
- Throughput: one word per k+2 cycles at best (accept, k COUNT cycles, DONE with out_ready=1).

Optional Feature:
- Macro: `POPCOUNT_PARITY_EN`.
- Defined:
  - Adds output port out_parity (1 bit) = out_count[0], i.e. odd parity of the accepted word.
  - Registered alongside out_count, 0 in reset, held under backpressure.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Release rst, send 32'h0000_0000 → k=1; out_valid after edge T+1; out_count=0; out_nonzero=0; (parity 0).
- Send 32'hFFFF_FFFF with out_ready=1 → k=8; out_count=32; out_nonzero=1; in_ready low for 9 cycles after the accept edge (8 COUNT + 1 DONE).
- Send 32'h0000_000F → early exit, k=1, out_count=4. Then send 32'h8000_0001 → k=8, out_count=2; (parity 0 for both).
- Backpressure: send 32'h0000_0700 with out_ready=0 for 5 cycles →
  - out_valid stays 1; out_count holds 3;
  - in_ready=0 throughout;
  - in_valid pulses with 32'hFFFF_FFFF are ignored;
  - raise out_ready → in_ready=1 one cycle later.
- Reset mid-COUNT: accept 32'hF000_0000, drop rst at chunk 3 →
  - immediately busy=0 and out_valid=0;
  - after release, 32'h0000_0001 yields out_count=1 with no residue from the aborted word.
- Concurrently bind an SVA checker: out_valid |-> out_count == $countones(captured word), disabled iff !rst; no failures over 200 random words.

Source files
------------

// File: rtl/popcount_engine.sv
// popcount_engine: counts the 1 bits of a WIDTH-bit word, CHUNK bits per clock, over valid/ready handshakes.
// Optional POPCOUNT_PARITY_EN adds the out_parity port (odd parity of the accepted word).
module popcount_engine #(
   parameter  int WIDTH = 32,
   parameter  int CHUNK = 4,
   localparam int CW    = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CW-1:0]    out_count,
   output logic             out_nonzero,
   output logic             busy
`ifdef POPCOUNT_PARITY_EN
   ,
   output logic             out_parity
`endif
);
   localparam int NCH = WIDTH / CHUNK;
   localparam int IW  = NCH > 1 ? $clog2(NCH) : 1;
   if ((WIDTH % CHUNK) != 0 || CHUNK > WIDTH) begin : g_bad_cfg
      $fatal(1, "popcount_engine: WIDTH must be a nonzero multiple of CHUNK");
   end
   typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
   state_t           state;
   logic [WIDTH-1:0] shreg;
   logic [CW-1:0]    acc, chunk_pc, acc_nxt;
   logic [IW-1:0]    idx;
   logic             last;
   always_comb begin
      chunk_pc = '0;
      for (int i = 0; i < CHUNK; i++) chunk_pc = chunk_pc + CW'(shreg[i]);
      acc_nxt = acc + chunk_pc;
      // stop once no set bits remain above the chunk being consumed
      last = ((shreg >> CHUNK) == '0) || (idx == IW'(NCH - 1));
   end
   assign busy = state != IDLE;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         shreg       <= '0;
         acc         <= '0;
         idx         <= '0;
         in_ready    <= 1'b0;
         out_valid   <= 1'b0;
         out_count   <= '0;
         out_nonzero <= 1'b0;
`ifdef POPCOUNT_PARITY_EN
         out_parity  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  shreg    <= in_data;
                  acc      <= '0;
                  idx      <= '0;
                  in_ready <= 1'b0;
                  state    <= COUNT;
               end
            end
            COUNT: begin
               acc   <= acc_nxt;
               shreg <= shreg >> CHUNK;
               idx   <= idx + IW'(1);
               if (last) begin
                  state       <= DONE;
                  out_valid   <= 1'b1;
                  out_count   <= acc_nxt;
                  out_nonzero <= acc_nxt != '0;
`ifdef POPCOUNT_PARITY_EN
                  out_parity  <= acc_nxt[0];
`endif
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_popcount_engine.sv
// tb_popcount_engine: directed table plus corner sequences and random words for popcount_engine.
module tb_popcount_engine;
   logic        clk = 0, rst = 0, in_valid = 0, out_ready = 0;
   logic [31:0] in_data = '0, cap = '0;
   logic        in_ready, out_valid, out_nonzero, busy;
   logic [5:0]  out_count;
   int          checks = 0, passes = 0;
`ifdef POPCOUNT_PARITY_EN
   logic        out_parity;
`endif
   popcount_engine dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_count(out_count),
      .out_nonzero(out_nonzero), .busy(busy)
`ifdef POPCOUNT_PARITY_EN
      , .out_parity(out_parity)
`endif
   );
   always #5 clk = ~clk;
   typedef struct {logic [31:0] w; int k; int cnt; int nz;} vec_t;
   vec_t vecs[8];
   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask
   function automatic int model_k(input logic [31:0] w);
      for (int i = 7; i >= 0; i--) if (w[i*4 +: 4] != 4'h0) return i + 1;
      return 1;
   endfunction
   always @(posedge clk) if (in_valid && in_ready) cap <= in_data;
   always @(negedge clk) if (rst && out_valid) chk("scoreboard_count", int'(out_count), $countones(cap));
   a_count: assert property (@(posedge clk) disable iff (!rst) out_valid |-> out_count == $countones(cap))
      else begin checks++; $display("FAIL sva_count: got %0d expected %0d", out_count, $countones(cap)); end
   task automatic xfer(input string name, input logic [31:0] w, input int ek, input int ec, input bit hold);
      int n = 0, k = 0, lows = 0;
      while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
      if (!in_ready) chk({name, "_accept_timeout"}, 0, 1);
      in_valid = 1; in_data = w; out_ready = !hold;
      @(posedge clk); #1;
      in_valid = 0; in_data = $urandom;
      while (!out_valid && k < 40) begin
         if (!in_ready) lows++;
         @(posedge clk); #1; k++;
      end
      chk({name, "_k"}, k, ek);
      chk({name, "_ready_low"}, lows, k);
      chk({name, "_count"}, int'(out_count), ec);
      chk({name, "_nonzero"}, int'(out_nonzero), int'(ec != 0));
`ifdef POPCOUNT_PARITY_EN
      chk({name, "_parity"}, int'(out_parity), ec % 2);
`endif
      chk({name, "_ready_done"}, int'(in_ready), 0);
      if (!hold) begin
         @(posedge clk); #1;
         chk({name, "_valid_drop"}, int'(out_valid), 0);
         chk({name, "_ready_back"}, int'(in_ready), 1);
         chk({name, "_busy_clear"}, int'(busy), 0);
      end
   endtask
   initial begin
      vecs = '{'{32'h0000_0000, 1, 0, 0}, '{32'hFFFF_FFFF, 8, 32, 1},
               '{32'h0000_000F, 1, 4, 1}, '{32'h8000_0001, 8, 2, 1},
               '{32'h0000_0700, 3, 3, 1}, '{32'h0000_0010, 2, 1, 1},
               '{32'h0F00_0000, 7, 4, 1}, '{32'hAAAA_AAAA, 8, 16, 1}};
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", int'(in_ready), 0);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_count", int'(out_count), 0);
      chk("rst_nonzero", int'(out_nonzero), 0);
      chk("rst_busy", int'(busy), 0);
      rst = 1;
      #1 chk("release_in_ready_low", int'(in_ready), 0);
      @(posedge clk); #1;
      chk("release_in_ready_high", int'(in_ready), 1);
      for (int i = 0; i < 8; i++) xfer($sformatf("vec%0d", i), vecs[i].w, vecs[i].k, vecs[i].cnt, 0);
      xfer("bp", 32'h0000_0700, 3, 3, 1);
      for (int c = 0; c < 5; c++) begin
         in_valid = c[0]; in_data = 32'hFFFF_FFFF;
         @(posedge clk); #1;
         chk("bp_valid", int'(out_valid), 1);
         chk("bp_count", int'(out_count), 3);
         chk("bp_in_ready", int'(in_ready), 0);
      end
      in_valid = 0; out_ready = 1;
      @(posedge clk); #1;
      chk("bp_release_ready", int'(in_ready), 1);
      chk("bp_release_valid", int'(out_valid), 0);
      xfer("bp_after", 32'h0000_0010, 2, 1, 0);
      in_valid = 1; in_data = 32'hF000_0000;
      @(posedge clk); #1;
      in_valid = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      #1;
      chk("abort_busy", int'(busy), 0);
      chk("abort_valid", int'(out_valid), 0);
      chk("abort_ready", int'(in_ready), 0);
      #2 rst = 1;
      @(posedge clk); #1;
      chk("abort_ready_back", int'(in_ready), 1);
      xfer("abort_next", 32'h0000_0001, 1, 1, 0);
      for (int r = 0; r < 200; r++) begin
         logic [31:0] w;
         w = $urandom;
         if (r % 4 == 1) w = w >> (r % 32);
         xfer($sformatf("rnd%0d", r), w, model_k(w), $countones(w), 0);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
